// File: rtl/instr_loader_if.sv
// Byte-stream loader bus: host-side request/stream signals and
// instruction-memory write port with status.
interface instr_loader_if #(
  parameter int ADDRESS_WIDTH = 16
);
  logic                     start;
  logic [ADDRESS_WIDTH-1:0] len;
  logic                     rx_valid;
  logic [7:0]               rx_data;
  logic                     rx_ready;
  logic                     we;
  logic [ADDRESS_WIDTH-1:0] waddr;
  logic [7:0]               wdata;
  logic                     cpu_hold;
  logic                     busy;
  logic                     done;
  logic [7:0]               checksum;

  modport master (
    output start, len, rx_valid, rx_data,
    input  rx_ready, we, waddr, wdata,
    input  cpu_hold, busy, done, checksum
  );

  modport slave (
    input  start, len, rx_valid, rx_data,
    output rx_ready, we, waddr, wdata,
    output cpu_hold, busy, done, checksum
  );
endinterface

// File: rtl/instr_loader.sv
// Program-image loader: streams bytes into instruction memory at
// consecutive addresses while holding the core in reset.
module instr_loader #(
  parameter int                       ADDRESS_WIDTH = 16,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = '0
) (
  input logic           clk,
  input logic           rst,
  instr_loader_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t state;
  state_t nextState;

  logic [ADDRESS_WIDTH-1:0] addr;
  logic [ADDRESS_WIDTH-1:0] remaining;
  logic [ADDRESS_WIDTH-1:0] waddr;
  logic [7:0]               wdata;
  logic [7:0]               checksum;
  logic                     we;
  logic                     rxReady;
  logic                     busy;
  logic                     done;
  logic                     cpuHold;
  logic                     accept;
  logic                     lastByte;

  assign accept   = rxReady && bus.rx_valid;
  assign lastByte = remaining == ADDRESS_WIDTH'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Handshake outputs depend on state only, never on rx_valid.
  always_comb begin
    nextState = state;
    rxReady   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    cpuHold   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          nextState = (bus.len == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        rxReady = 1'b1;
        busy    = 1'b1;
        cpuHold = 1'b1;
        if (bus.rx_valid && lastByte) begin
          nextState = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        cpuHold   = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr      <= BASE_ADDR;
      remaining <= '0;
      checksum  <= '0;
      we        <= 1'b0;
      waddr     <= '0;
      wdata     <= '0;
    end else begin
      we <= 1'b0;
      if (state == IDLE && bus.start) begin
        remaining <= bus.len;
        addr      <= BASE_ADDR;
        checksum  <= '0;
      end
      if (accept) begin
        we        <= 1'b1;
        waddr     <= addr;
        wdata     <= bus.rx_data;
        addr      <= addr + ADDRESS_WIDTH'(1);
        checksum  <= checksum + bus.rx_data;
        remaining <= remaining - ADDRESS_WIDTH'(1);
      end
    end
  end

  assign bus.rx_ready = rxReady;
  assign bus.we       = we;
  assign bus.waddr    = waddr;
  assign bus.wdata    = wdata;
  assign bus.cpu_hold = cpuHold;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.checksum = checksum;

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: two instances (base 0 and base 0xFFFE)
// share one input stream; writes are checked against an image model.
module tb_instr_loader;
  localparam int AW  = 16;
  localparam int TMO = 2000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   ec  = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) ec++;

  instr_loader_if #(.ADDRESS_WIDTH(AW)) busA ();
  instr_loader_if #(.ADDRESS_WIDTH(AW)) busB ();

  assign busB.start    = busA.start;
  assign busB.len      = busA.len;
  assign busB.rx_valid = busA.rx_valid;
  assign busB.rx_data  = busA.rx_data;

  instr_loader #(.ADDRESS_WIDTH(AW), .BASE_ADDR(16'h0000)) dutA (
    .clk(clk), .rst(rst), .bus(busA.slave)
  );
  instr_loader #(.ADDRESS_WIDTH(AW), .BASE_ADDR(16'hFFFE)) dutB (
    .clk(clk), .rst(rst), .bus(busB.slave)
  );

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
    logic [31:0] e;
  } wr_t;

  wr_t        wqA[$];
  wr_t        wqB[$];
  int         doneA, doneB, doneEdgeA, doneEdgeB, holdA, holdB;
  logic [7:0] memA [0:65535];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (busA.we) begin
        wqA.push_back(wr_t'{busA.waddr, busA.wdata, 32'(ec)});
        memA[busA.waddr] = busA.wdata;
        chk("weWithHoldA", busA.cpu_hold, 1);
      end
      if (busB.we) wqB.push_back(wr_t'{busB.waddr, busB.wdata, 32'(ec)});
      if (busA.done) begin doneA++; doneEdgeA = ec; end
      if (busB.done) begin doneB++; doneEdgeB = ec; end
      if (busA.cpu_hold) holdA++;
      if (busB.cpu_hold) holdB++;
    end
  end

  // One complete load; expectations come from the image and the
  // edges on which this task saw its own bytes accepted.
  task automatic doLoad(input logic [7:0] img[$], input int gapAt,
                        input int gapLen, input int gapPct,
                        input int startAt, output int startEdge,
                        output logic [7:0] sum);
    int          n, i, it, gapDone;
    logic        v, acc;
    logic [31:0] accE[$];
    n = img.size();
    sum = 8'h00;
    foreach (img[k]) sum += img[k];
    wqA.delete(); wqB.delete();
    doneA = 0; doneB = 0; holdA = 0; holdB = 0;
    doneEdgeA = -1; doneEdgeB = -1;
    busA.start = 1'b1;
    busA.len = AW'(n);
    busA.rx_valid = 1'b0;
    @(posedge clk); #1;
    startEdge = ec;
    busA.start = 1'b0;
    busA.len = AW'($urandom);
    chk("readyAfterStart", busA.rx_ready, n != 0);
    chk("doneAfterStart", busA.done, n == 0);
    i = 0; it = 0; gapDone = 0;
    while (i < n && it < TMO) begin
      v = 1'b1;
      if (i == gapAt && gapDone < gapLen) begin
        v = 1'b0;
        gapDone++;
      end else if ($urandom_range(99) < gapPct) begin
        v = 1'b0;
      end
      busA.rx_valid = v;
      busA.rx_data = v ? img[i] : 8'($urandom);
      busA.start = (it == startAt);
      if (it == startAt) busA.len = AW'(1);
      acc = v && busA.rx_ready;
      @(posedge clk); #1;
      it++;
      if (acc) begin
        accE.push_back(32'(ec));
        i++;
      end
    end
    busA.rx_valid = 1'b0;
    busA.start = 1'b0;
    chk("loadTimeout", it < TMO, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("writesA", wqA.size(), n);
    chk("writesB", wqB.size(), n);
    for (int k = 0; k < n && k < wqA.size() && k < wqB.size(); k++) begin
      chk("wrA", {wqA[k].a, wqA[k].d, wqA[k].e},
          {16'(k), img[k], accE[k]});
      chk("wrB", {wqB[k].a, wqB[k].d, wqB[k].e},
          {16'(32'hFFFE + k), img[k], accE[k]});
    end
    chk("doneCntA", doneA, 1);
    chk("doneCntB", doneB, 1);
    chk("doneEdgeA", doneEdgeA, startEdge + it);
    chk("doneEdgeB", doneEdgeB, startEdge + it);
    chk("holdCyclesA", holdA, it + 1);
    chk("holdCyclesB", holdB, it + 1);
    chk("checksumA", busA.checksum, sum);
    chk("checksumB", busB.checksum, sum);
    chk("idleOutsA", {busA.cpu_hold, busA.busy, busA.rx_ready, busA.we}, 0);
  endtask

  typedef struct {
    int         n;
    int         gapAt;
    int         gapLen;
    int         startAt;
    logic [7:0] b [4];
    logic [7:0] expCk;
    int         expDelay;
  } vec_t;

  vec_t       vecs [4];
  logic [7:0] img[$];
  int         se;
  logic [7:0] sum;

  initial begin
    vecs[0] = '{4, -1, 0, -1, '{8'h13, 8'h05, 8'h00, 8'h00}, 8'h18, 4};
    vecs[1] = '{4, 2, 2, -1, '{8'h13, 8'h05, 8'h00, 8'h00}, 8'h18, 6};
    vecs[2] = '{0, -1, 0, -1, '{8'h00, 8'h00, 8'h00, 8'h00}, 8'h00, 0};
    vecs[3] = '{4, -1, 0, 2, '{8'hFF, 8'h80, 8'h01, 8'h7F}, 8'hFF, 4};

    busA.start = 1'b0;
    busA.len = '0;
    busA.rx_valid = 1'b0;
    busA.rx_data = '0;
    @(posedge clk); @(posedge clk); #1;
    chk("resetA", {busA.we, busA.waddr, busA.wdata, busA.rx_ready,
        busA.busy, busA.done, busA.cpu_hold, busA.checksum}, 0);
    chk("resetB", {busB.we, busB.waddr, busB.checksum, busB.cpu_hold}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int t = 0; t < 4; t++) begin
      img.delete();
      for (int k = 0; k < vecs[t].n; k++) img.push_back(vecs[t].b[k]);
      doLoad(img, vecs[t].gapAt, vecs[t].gapLen, 0, vecs[t].startAt,
             se, sum);
      chk("vecChecksum", busA.checksum, vecs[t].expCk);
      chk("vecDoneDelay", doneEdgeA - se, vecs[t].expDelay);
      if (t == 0)
        chk("memWord0", {memA[3], memA[2], memA[1], memA[0]}, 32'h00000513);
    end

    busA.start = 1'b1;
    busA.len = AW'(8);
    @(posedge clk); #1;
    busA.start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      busA.rx_valid = 1'b1;
      busA.rx_data = 8'(k + 8'h41);
      @(posedge clk); #1;
    end
    busA.rx_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midRstA", {busA.we, busA.waddr, busA.wdata, busA.rx_ready,
        busA.busy, busA.done, busA.cpu_hold, busA.checksum}, 0);
    chk("midRstB", {busB.we, busB.waddr, busB.cpu_hold, busB.checksum}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    img = '{8'h5A, 8'hC3};
    doLoad(img, -1, 0, 0, -1, se, sum);

    for (int r = 0; r < 25; r++) begin
      img.delete();
      for (int k = 0; k < $urandom_range(24); k++)
        img.push_back(8'($urandom));
      doLoad(img, -1, 0, 25, $urandom_range(10), se, sum);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_loader.md
# instr_loader

Byte-stream loader that writes a program image into the byte-addressed instruction memory before the core runs. It accepts bytes over a valid/ready handshake and issues one byte write per accepted byte at consecutive addresses, so instruction words land little-endian. It holds the core in reset (`cpu_hold`) for the whole load. It reports completion and an 8-bit additive checksum of the image.

## Interface
Parameters:
- `ADDRESS_WIDTH`, 16: byte address width; matches the instruction memory.
- `BASE_ADDR`, 0: first byte address written by every load.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  load request; sampled only in IDLE.
- `len`  in  ADDRESS_WIDTH  number of bytes to load; latched when `start` is accepted.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_data`  in  8  image byte.
- `rx_ready`  out  1  loader accepts a byte this cycle.
- `we`  out  1  byte write strobe to the instruction memory.
- `waddr`  out  ADDRESS_WIDTH  write byte address.
- `wdata`  out  8  write byte.
- `cpu_hold`  out  1  keeps the core in reset while high.
- `busy`  out  1  high in LOAD.
- `done`  out  1  one-cycle completion pulse.
- `checksum`  out  8  running sum of accepted bytes, mod 256.

## Operation
- States: IDLE, LOAD, DONE.
- **IDLE:**
  - `rx_ready`=0.
  - On `start`=1: latch `len` into `remaining`, set `addr`=BASE_ADDR, clear `checksum`.
  - If `len`≠0, go to LOAD. If `len`=0, go to DONE with no writes.
- **LOAD:**
  - `rx_ready`=1 and `busy`=1.
  - A handshake occurs on the edge where `rx_valid`&&`rx_ready`. On a handshake:
    - Register `we`<=1, `waddr`<=`addr`, `wdata`<=`rx_data`.
    - `addr`<=`addr`+1, wrapping modulo 2^ADDRESS_WIDTH.
    - `checksum`<=`checksum`+`rx_data`, mod 256.
    - `remaining`<=`remaining`-1.
  - On the handshake where `remaining`=1, go to DONE.
  - `start` is ignored in LOAD.
  - `rx_valid` low holds all state, with `we`=0 the following cycle.
- **DONE:**
  - Lasts exactly one cycle with `done`=1 and `rx_ready`=0, then returns to IDLE.
  - The final byte's write strobe is active during this cycle.
  - `start` is ignored in DONE.
- `we` is high only in the cycle after a handshake. It is never high in IDLE, except in the cycle following a DONE state that was entered from `len`=0, where `we`=0 anyway.
- `cpu_hold`=1 in LOAD and DONE, 0 in IDLE. The core is therefore released only after the last write has been issued.
- `checksum` holds its value in IDLE until the next accepted `start`.
- `len` changes after `start` is accepted have no effect.

## Timing
- Reset (async, immediate):
  - State IDLE.
  - `we`=0, `waddr`=0, `wdata`=0.
  - `rx_ready`=0, `busy`=0, `done`=0, `cpu_hold`=0, `checksum`=0.
  - `addr`=BASE_ADDR, `remaining`=0.
- `rst` asserted mid-load aborts the load. There is no resume; bytes already written remain in memory.
- Cycle after `start` in IDLE: `rx_ready`=1, or `done`=1 if `len`=0.
- Write latency: `we`/`waddr`/`wdata` are valid exactly 1 cycle after the accepting edge.
- Throughput: one byte per cycle with `rx_valid` held high. N bytes take N cycles of LOAD plus 1 cycle of DONE.
- `done` pulse coincides with the last `we`.
- `cpu_hold` falls on the edge after `done`.
- `rx_ready` does not depend combinationally on `rx_valid`; it is a function of state only.

## Test plan
- **Basic load:** `start`, `len`=4, bytes 0x13,0x05,0x00,0x00 on 4 consecutive cycles.
  - Writes (0,0x13),(1,0x05),(2,0x00),(3,0x00) on cycles 2–5.
  - `done` on cycle 5; `checksum`=0x18.
  - Memory read at PC=0 returns 0x00000513.
- **Backpressure:** same image with `rx_valid` low for 2 cycles between bytes 2 and 3.
  - Identical writes and checksum.
  - `we`=0 during the gap; `done` arrives 2 cycles later.
- **Zero length:** `start` with `len`=0.
  - `done` the next cycle, no `we`, `checksum`=0.
  - `cpu_hold` high for 1 cycle.
- **Address wrap:** BASE_ADDR=0xFFFE, `len`=4.
  - `waddr` sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- **Reset mid-load:** `len`=8, assert `rst` after 3 bytes.
  - All outputs go to reset values without waiting for a clock edge; no further `we`.
  - A new `start` with `len`=2 writes from BASE_ADDR with `checksum` restarted at 0.
- **Ignored start:** pulse `start` with `len`=1 during LOAD of a 4-byte image.
  - Exactly 4 writes occur, with a single `done` pulse.
